// File: rtl/dram_ctrl_pkg.sv
// Shared encodings and default timing for the DRAM command scheduler.
// The default timing values assume a 320 MHz clock.
package dram_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] cmd_sel_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_ISSUE     = 2'd1;
    localparam state_t ST_WAIT_DONE = 2'd2;

    localparam cmd_sel_t SEL_NONE  = 2'd0;
    localparam cmd_sel_t SEL_REF   = 2'd1;
    localparam cmd_sel_t SEL_WRITE = 2'd2;
    localparam cmd_sel_t SEL_READ  = 2'd3;

    localparam logic [31:0] REFI_CYCLES     = 32'd2496;
    localparam logic [15:0] DEBOUNCE_CYCLES = 16'd3200;
    localparam logic [15:0] ACK_TIMEOUT     = 16'd64;
    localparam logic [3:0]  MAX_REF_DEBT    = 4'd8;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: two-flop synchronizer, level debouncer and a
// one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
    import dram_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = dram_ctrl_pkg::DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_rise;
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_rise <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= 16'd0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Arbitrates refresh, button-driven write and button-driven read requests
// into single REF/WRITE/READ command levels for the DRAM state machine.
module dram_cmd_scheduler
    import dram_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = dram_ctrl_pkg::DEBOUNCE_CYCLES,
    parameter logic [31:0] REFI_CYCLES     = dram_ctrl_pkg::REFI_CYCLES,
    parameter logic [3:0]  MAX_REF_DEBT    = dram_ctrl_pkg::MAX_REF_DEBT,
    parameter logic [15:0] ACK_TIMEOUT     = dram_ctrl_pkg::ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       RESET_SM_button,
    input  logic       btnl,
    input  logic       btnr,
    input  logic       sm_idle,
    output logic       REF,
    output logic       WRITE,
    output logic       READ,
    output logic [3:0] ref_debt,
    output logic       busy,
    output logic       cmd_err
);

    state_t      r_state;
    cmd_sel_t    r_sel;
    logic        r_ref;
    logic        r_write;
    logic        r_read;
    logic        r_cmd_err;
    logic        r_wr_pend;
    logic        r_rd_pend;
    logic [3:0]  r_ref_debt;
    logic [31:0] r_timer;
    logic [15:0] r_ack_cnt;

    logic        w_wr_rise;
    logic        w_rd_rise;
    logic        w_wrap;
    logic        w_done;
    logic        w_ref_done;
    logic        w_wr_clr;
    logic        w_rd_clr;
    cmd_sel_t    w_pick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_wr (
        .i_clk   (clk),
        .i_reset (RESET_SM_button),
        .i_btn   (btnl),
        .o_rise  (w_wr_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rd (
        .i_clk   (clk),
        .i_reset (RESET_SM_button),
        .i_btn   (btnr),
        .o_rise  (w_rd_rise)
    );

    assign w_wrap     = (r_timer == REFI_CYCLES - 32'd1);
    assign w_done     = (r_state == ST_WAIT_DONE) && sm_idle;
    assign w_ref_done = w_done && (r_sel == SEL_REF);
    assign w_wr_clr   = w_done && (r_sel == SEL_WRITE);
    assign w_rd_clr   = w_done && (r_sel == SEL_READ);

    // Urgent refresh beats everything; leftover debt is paid only when nothing else waits
    always_comb begin
        w_pick = SEL_NONE;
        if (r_ref_debt >= MAX_REF_DEBT)
            w_pick = SEL_REF;
        else if (r_wr_pend)
            w_pick = SEL_WRITE;
        else if (r_rd_pend)
            w_pick = SEL_READ;
        else if (r_ref_debt != 4'd0)
            w_pick = SEL_REF;
    end

    always_ff @(posedge clk or posedge RESET_SM_button) begin
        if (RESET_SM_button)
            r_timer <= 32'd0;
        else if (w_wrap)
            r_timer <= 32'd0;
        else
            r_timer <= r_timer + 32'd1;
    end

    // A wrap and a completed refresh in the same cycle cancel out
    always_ff @(posedge clk or posedge RESET_SM_button) begin
        if (RESET_SM_button) begin
            r_ref_debt <= 4'd0;
        end else if (w_wrap && !w_ref_done) begin
            if (r_ref_debt != 4'd15)
                r_ref_debt <= r_ref_debt + 4'd1;
        end else if (!w_wrap && w_ref_done) begin
            r_ref_debt <= r_ref_debt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge RESET_SM_button) begin
        if (RESET_SM_button) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_wr_pend <= w_wr_rise | (r_wr_pend & ~w_wr_clr);
            r_rd_pend <= w_rd_rise | (r_rd_pend & ~w_rd_clr);
        end
    end

    always_ff @(posedge clk or posedge RESET_SM_button) begin
        if (RESET_SM_button) begin
            r_state   <= ST_IDLE;
            r_sel     <= SEL_NONE;
            r_ref     <= 1'b0;
            r_write   <= 1'b0;
            r_read    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_ack_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sm_idle && (w_pick != SEL_NONE)) begin
                        r_sel     <= w_pick;
                        r_ref     <= (w_pick == SEL_REF);
                        r_write   <= (w_pick == SEL_WRITE);
                        r_read    <= (w_pick == SEL_READ);
                        r_ack_cnt <= 16'd0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The DRAM state machine leaving IDLE is the acknowledge
                    if (!sm_idle) begin
                        {r_ref, r_write, r_read} <= 3'b000;
                        r_state <= ST_WAIT_DONE;
                    end else if (r_ack_cnt == ACK_TIMEOUT - 16'd1) begin
                        {r_ref, r_write, r_read} <= 3'b000;
                        r_cmd_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 16'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (sm_idle)
                        r_state <= ST_IDLE;
                end
                default: begin
                    {r_ref, r_write, r_read} <= 3'b000;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign REF      = r_ref;
    assign WRITE    = r_write;
    assign READ     = r_read;
    assign ref_debt = r_ref_debt;
    assign busy     = (r_state != ST_IDLE);
    assign cmd_err  = r_cmd_err;

endmodule

// File: doc/dram_cmd_scheduler.md
DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16'd3200, consecutive stable clk cycles required to accept a button level (10 us at 320 MHz).
REQ-002 Parameter: REFI_CYCLES, 32'd2496, refresh interval in clk cycles (7.8 us at 320 MHz).
REQ-003 Parameter: MAX_REF_DEBT, 4'd8, owed refreshes at which refresh becomes urgent.
REQ-004 Parameter: ACK_TIMEOUT, 16'd64, max cycles a command is held while waiting for controller acknowledge.
REQ-005 Port: clk input 1, system clock (320 MHz); all logic on rising edge.
REQ-006 Port: RESET_SM_button input 1, reset, asynchronous, active-high.
REQ-007 Port: btnl input 1, raw asynchronous write button.
REQ-008 Port: btnr input 1, raw asynchronous read button.
REQ-009 Port: sm_idle input 1, high while the DRAM state machine sits in its IDLE state.
REQ-010 Port: REF output 1, refresh command level to the DRAM state machine.
REQ-011 Port: WRITE output 1, write command level to the DRAM state machine.
REQ-012 Port: READ output 1, read command level to the DRAM state machine.
REQ-013 Port: ref_debt output 4, count of owed refreshes.
REQ-014 Port: busy output 1, high in any state other than IDLE.
REQ-015 Port: cmd_err output 1, sticky acknowledge-timeout flag.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer updating its stable level only after DEBOUNCE_CYCLES identical synchronized samples.
REQ-017 A 0->1 transition of a debounced level SHALL set the matching pending flag (wr_pend / rd_pend); a press while the flag is already set SHALL be dropped.
REQ-018 Refresh timer SHALL count 0..REFI_CYCLES-1 and wrap; each wrap SHALL increment ref_debt, saturating at 15.
REQ-019 FSM states: IDLE, ISSUE, WAIT_DONE; encoding from shared package.
REQ-020 IDLE: when sm_idle=1 and any request exists, select by priority: REF if ref_debt>=MAX_REF_DEBT; else WRITE if wr_pend; else READ if rd_pend; else REF if ref_debt>0; next state ISSUE.
REQ-021 ISSUE: selected output SHALL be high, registered, starting the cycle after selection; at most one of REF/WRITE/READ high in any cycle.
REQ-022 ISSUE: sm_idle=0 is acknowledge; output drops next cycle, next state WAIT_DONE.
REQ-023 ISSUE: ACK_TIMEOUT cycles without acknowledge SHALL drop the output, set cmd_err, return to IDLE, leaving the pending flag/debt unchanged (retried).
REQ-024 WAIT_DONE: on sm_idle=1 SHALL clear the served pending flag or decrement ref_debt, then IDLE.
REQ-025 Timer wrap in the same cycle as a refresh completion SHALL leave ref_debt unchanged (+1 -1).
REQ-026 Button edge in the cycle its flag is cleared SHALL re-set the flag (set wins).
REQ-027 Requests arriving during ISSUE/WAIT_DONE SHALL be latched and arbitrated only on return to IDLE; no pre-emption.

Reset
REQ-028 RESET_SM_button SHALL asynchronously force: state IDLE, REF/WRITE/READ=0, busy=0, cmd_err=0, ref_debt=0, pending flags=0, timer=0, debouncer levels/counters=0, synchronizers=0.
REQ-029 Reset mid-command SHALL drop the command output immediately; the lost command is not replayed.

Structure
REQ-030 Package dram_ctrl_pkg SHALL hold FSM state encoding, command select encoding, and default timing constants (REFI_CYCLES, DEBOUNCE_CYCLES, ACK_TIMEOUT, MAX_REF_DEBT).
REQ-031 Sub-module btn_debounce (synchronizer + debouncer + rising-edge pulse) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4, REFI_CYCLES=100, ACK_TIMEOUT=8, MAX_REF_DEBT=8)
REQ-032 btnl high 10 cycles, sm_idle models 5-cycle busy -> exactly one WRITE pulse, ack then done, wr_pend cleared, busy low afterward; 2-cycle glitch -> no command.
REQ-033 btnl and btnr same cycle, ref_debt=0 -> WRITE served then READ, never both high.
REQ-034 sm_idle held 0 for 900 cycles -> ref_debt reaches 8; on release REF issued before pending WRITE; ref_debt 9->8 after done.
REQ-035 sm_idle held 1 (no ack) during WRITE -> output drops after 8 cycles, cmd_err=1, WRITE re-issued next IDLE.
REQ-036 Timer wrap coincident with REF completion, ref_debt=3 -> stays 3.
REQ-037 RESET_SM_button asserted mid-ISSUE -> all outputs 0 same cycle asynchronously, ref_debt=0, no replay after release.
